// File: rtl/button_debounce.sv
// button_debounce
//   Turns one raw, bouncing push-button into clean single-cycle control
//   strobes. The raw input passes through a 2-flop synchronizer, then a
//   stability-counter debounce. A hold-to-repeat FSM produces auto-fire
//   strobes while the button is held.
//
// Ports
//   iClk     system clock; all state changes on its rising edge
//   iRst_n   asynchronous, active-low reset
//   iButton  raw asynchronous button input
//   oLevel   debounced level, 1 = pressed (polarity normalised)
//   oPress   one-cycle strobe on accepted press
//   oRelease one-cycle strobe on accepted release
//   oRepeat  one-cycle strobe on press, then at each auto-repeat interval
module button_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int CNT_W           = 25
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iButton,
  output logic oLevel,
  output logic oPress,
  output logic oRelease,
  output logic oRepeat
);

  // Raw value of an idle (not pressed) button.
  localparam logic REST_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam bit   RPT_EN   = (REPEAT_DELAY != 0);

  localparam logic [CNT_W-1:0] DB_TC     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_TC  = RPT_EN ? CNT_W'(REPEAT_DELAY - 1) : '0;
  localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rptState_t;

  logic             sync_p0;
  logic             sync_p1;
  logic             pressedSync;
  logic [CNT_W-1:0] dbCnt;
  logic             levelDiffers;
  logic             dbTerm;
  logic             acceptPress;
  logic             acceptRelease;

  rptState_t        rptState;
  rptState_t        rptStateNext;
  logic [CNT_W-1:0] rptCnt;
  logic [CNT_W-1:0] rptCntNext;
  logic             repeatNext;

  // Stage p0/p1: two-flop synchronizer, reset to the idle raw value so that
  // deassertion never looks like a press.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync_p0 <= REST_RAW;
      sync_p1 <= REST_RAW;
    end else begin
      sync_p0 <= iButton;
      sync_p1 <= sync_p0;
    end
  end

  assign pressedSync   = sync_p1 ^ REST_RAW;
  assign levelDiffers  = (pressedSync != oLevel);
  assign dbTerm        = (dbCnt == DB_TC);
  assign acceptPress   = levelDiffers && dbTerm && pressedSync;
  assign acceptRelease = levelDiffers && dbTerm && !pressedSync;

  // Debounce stage: the counter only runs while the synchronized input
  // disagrees with the accepted level; any agreement restarts it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      dbCnt    <= '0;
      oLevel   <= 1'b0;
      oPress   <= 1'b0;
      oRelease <= 1'b0;
    end else begin
      oPress   <= acceptPress;
      oRelease <= acceptRelease;
      if (!levelDiffers) begin
        dbCnt <= '0;
      end else if (dbTerm) begin
        dbCnt  <= '0;
        oLevel <= pressedSync;
      end else begin
        dbCnt <= dbCnt + 1'b1;
      end
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rptState <= IDLE;
      rptCnt   <= '0;
      oRepeat  <= 1'b0;
    end else begin
      rptState <= rptStateNext;
      rptCnt   <= rptCntNext;
      oRepeat  <= repeatNext;
    end
  end

  // Release has priority over any terminal count in the same cycle, so a
  // release never emits a trailing repeat strobe.
  always_comb begin
    rptStateNext = rptState;
    rptCntNext   = rptCnt;
    repeatNext   = 1'b0;
    if (acceptRelease) begin
      rptStateNext = IDLE;
      rptCntNext   = '0;
    end else begin
      case (rptState)
        IDLE: begin
          if (acceptPress) begin
            repeatNext = 1'b1;
            rptCntNext = '0;
            if (RPT_EN) rptStateNext = DELAY;
          end
        end
        DELAY: begin
          if (rptCnt == DELAY_TC) begin
            repeatNext   = 1'b1;
            rptCntNext   = '0;
            rptStateNext = REPEAT;
          end else begin
            rptCntNext = rptCnt + 1'b1;
          end
        end
        REPEAT: begin
          if (rptCnt == PERIOD_TC) begin
            repeatNext = 1'b1;
            rptCntNext = '0;
          end else begin
            rptCntNext = rptCnt + 1'b1;
          end
        end
        default: begin
          rptStateNext = IDLE;
          rptCntNext   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Directed bench for button_debounce. Three instances cover the parameter
//   sets of interest: A (active-low, debounce 4, no repeat), B (active-low,
//   debounce 4, delay 10, period 3) and C (active-high, debounce 1).
module tb_button_debounce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA_n, btnA, levelA, pressA, releaseA, repeatA;
  logic rstB_n, btnB, levelB, pressB, releaseB, repeatB;
  logic rstC_n, btnC, levelC, pressC, releaseC, repeatC;

  int nTests = 0;
  int nFail  = 0;

  button_debounce #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0),
    .REPEAT_PERIOD(1), .CNT_W(8)
  ) dutA (
    .iClk(clk), .iRst_n(rstA_n), .iButton(btnA),
    .oLevel(levelA), .oPress(pressA), .oRelease(releaseA), .oRepeat(repeatA)
  );

  button_debounce #(
    .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10),
    .REPEAT_PERIOD(3), .CNT_W(8)
  ) dutB (
    .iClk(clk), .iRst_n(rstB_n), .iButton(btnB),
    .oLevel(levelB), .oPress(pressB), .oRelease(releaseB), .oRepeat(repeatB)
  );

  button_debounce #(
    .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(1)
  ) dutC (
    .iClk(clk), .iRst_n(rstC_n), .iButton(btnC),
    .oLevel(levelC), .oPress(pressC), .oRelease(releaseC), .oRepeat(repeatC)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int cnt;

  initial begin
    rstA_n = 1'b0; rstB_n = 1'b0; rstC_n = 1'b0;
    btnA = 1'b1; btnB = 1'b1; btnC = 1'b0;
    #12;
    check("rstA level", 32'(levelA), 0);
    check("rstA strobes", 32'({pressA, releaseA, repeatA}), 0);
    check("rstB level", 32'(levelB), 0);
    check("rstC level", 32'(levelC), 0);
    rstA_n = 1'b1; rstB_n = 1'b1; rstC_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      cnt += int'(pressA) + int'(releaseA) + int'(repeatA) + int'(pressB)
           + int'(repeatB) + int'(pressC) + int'(releaseC) + int'(levelC);
    end
    check("post-reset idle strobes", 32'(cnt), 0);

    // Test 1: clean press on A
    btnA = 1'b0;
    tick(5);
    check("t1 level before edge6", 32'(levelA), 0);
    check("t1 press before edge6", 32'(pressA), 0);
    tick(1);
    check("t1 level edge6", 32'(levelA), 1);
    check("t1 press edge6", 32'(pressA), 1);
    check("t1 repeat edge6", 32'(repeatA), 1);
    check("t1 release edge6", 32'(releaseA), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      cnt += int'(pressA) + int'(repeatA);
    end
    check("t1 no further strobes", 32'(cnt), 0);
    check("t1 level held", 32'(levelA), 1);

    // Test 2: release A, then bouncing press
    btnA = 1'b1;
    tick(5);
    check("t2 release before edge6", 32'(releaseA), 0);
    tick(1);
    check("t2 release edge6", 32'(releaseA), 1);
    check("t2 level after release", 32'(levelA), 0);
    tick(1);
    check("t2 release one cycle", 32'(releaseA), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btnA = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(1);
      cnt += int'(pressA) + int'(releaseA) + int'(levelA);
      tick(1);
      cnt += int'(pressA) + int'(releaseA) + int'(levelA);
    end
    check("t2 no strobe while bouncing", 32'(cnt), 0);
    btnA = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      cnt += int'(pressA);
    end
    check("t2 no early press", 32'(cnt), 0);
    tick(1);
    check("t2 press edge6", 32'(pressA), 1);
    check("t2 level edge6", 32'(levelA), 1);

    // Test 3: auto-repeat on B (repeat at +0, +10, +13, +16 ...)
    btnB = 1'b0;
    tick(6);
    check("t3 press accept", 32'(pressB), 1);
    check("t3 repeat +0", 32'(repeatB), 1);
    for (int k = 1; k <= 31; k++) begin
      tick(1);
      check($sformatf("t3 repeat +%0d", k), 32'(repeatB),
            32'(k >= 10 && (k - 10) % 3 == 0));
    end

    // Test 4: release timed so acceptance lands on a repeat terminal (+37)
    btnB = 1'b1;
    for (int k = 32; k <= 36; k++) begin
      tick(1);
      check($sformatf("t4 repeat +%0d", k), 32'(repeatB), 32'(k == 34));
      check($sformatf("t4 no release +%0d", k), 32'(releaseB), 0);
    end
    tick(1);
    check("t4 release edge6", 32'(releaseB), 1);
    check("t4 repeat suppressed", 32'(repeatB), 0);
    check("t4 level low", 32'(levelB), 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      cnt += int'(repeatB) + int'(pressB) + int'(releaseB);
    end
    check("t4 quiet after release", 32'(cnt), 0);

    // Test 5: async reset while in REPEAT, button held
    btnB = 1'b0;
    tick(6);
    check("t5 press accept", 32'(pressB), 1);
    tick(15);
    check("t5 level before reset", 32'(levelB), 1);
    #2;
    rstB_n = 1'b0;
    #1;
    check("t5 level in reset", 32'(levelB), 0);
    check("t5 strobes in reset", 32'({pressB, releaseB, repeatB}), 0);
    #2;
    rstB_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      cnt += int'(pressB) + int'(levelB) + int'(repeatB);
    end
    check("t5 nothing before edge6", 32'(cnt), 0);
    tick(1);
    check("t5 press edge6", 32'(pressB), 1);
    check("t5 repeat edge6", 32'(repeatB), 1);

    // Test 6: active-high, debounce 1 on C
    btnC = 1'b1;
    tick(2);
    check("t6 level before edge3", 32'(levelC), 0);
    tick(1);
    check("t6 level edge3", 32'(levelC), 1);
    check("t6 press edge3", 32'(pressC), 1);
    check("t6 repeat edge3", 32'(repeatC), 1);
    tick(1);
    check("t6 press one cycle", 32'(pressC), 0);
    btnC = 1'b0;
    tick(2);
    check("t6 release before edge3", 32'(releaseC), 0);
    tick(1);
    check("t6 release edge3", 32'(releaseC), 1);
    check("t6 level low", 32'(levelC), 0);
    check("t6 no press with release", 32'(pressC), 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
